// File: rtl/quad_sum_unpack.sv
`default_nettype none
// ============================================================================
// Module      : quad_sum_unpack
// Description : Unpacks a 48-bit FOUR12 sum word (four 12-bit lanes plus a
//               per-lane carry) into a stream of 13-bit lane results, one
//               lane per cycle, with valid/ready handshakes on both sides.
//               A saturating counter tracks emitted lanes whose carry is set.
//
// Parameters  : LANE_DESCEND  0 = emit lanes 0,1,2,3; 1 = emit lanes 3,2,1,0
//               OVF_CNT_W     width of the overflow counter
//
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_sum     packed word, lane n = bits [12n+11:12n]
//               in_carry   per-lane carry, bit n belongs to lane n
//               in_valid   input word valid
//               in_ready   input word accepted this cycle
//               out_sum    {carry, 12-bit sum} of the current lane
//               out_lane   index of the current lane
//               out_last   current lane is the final lane of the word
//               out_valid  out_* valid
//               out_ready  downstream accepts out_* this cycle
//               ovf_clr    synchronous clear of ovf_cnt (wins over increment)
//               ovf_cnt    saturating count of emitted lanes with carry set
//
// Build macro : QUAD_SUM_UNPACK_SATURATE_EN - when defined, a lane with its
//               carry set is emitted clamped to 13'h0FFF.
//
// Revision    : 1.0 - initial release
// ============================================================================
module quad_sum_unpack #(
   parameter int LANE_DESCEND = 0,
   parameter int OVF_CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [47:0]          in_sum,
   input  logic [3:0]           in_carry,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [12:0]          out_sum,
   output logic [1:0]           out_lane,
   output logic                 out_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   input  logic                 ovf_clr,
   output logic [OVF_CNT_W-1:0] ovf_cnt
);

   localparam logic [0:0] c_st_empty = 1'b0;
   localparam logic [0:0] c_st_shift = 1'b1;

   localparam logic [1:0] c_first_lane = (LANE_DESCEND != 0) ? 2'd3 : 2'd0;
   localparam logic [1:0] c_last_lane  = (LANE_DESCEND != 0) ? 2'd0 : 2'd3;

   localparam logic [OVF_CNT_W-1:0] c_ovf_max = '1;
   localparam logic [OVF_CNT_W-1:0] c_ovf_one = OVF_CNT_W'(1);

   logic [0:0]           r_state;
   logic [0:0]           w_state_nxt;
   logic [47:0]          r_sum;
   logic [3:0]           r_carry;
   logic [1:0]           r_ptr;
   logic [1:0]           w_ptr_step;
   logic [OVF_CNT_W-1:0] r_ovf_cnt;
   logic [11:0]          w_lane_sum;
   logic                 w_lane_carry;
   logic                 w_in_fire;
   logic                 w_out_fire;

   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   // Pointer walks upward or downward; wrap-around past the last lane is
   // harmless because the next word always reloads the first lane.
   assign w_ptr_step = (LANE_DESCEND != 0) ? (r_ptr - 2'd1) : (r_ptr + 2'd1);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_empty;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_empty: begin
            if (w_in_fire) begin
               w_state_nxt = c_st_shift;
            end
         end
         c_st_shift: begin
            // Leaving the last lane: a coincident new word keeps us shifting.
            if (w_out_fire && out_last && !w_in_fire) begin
               w_state_nxt = c_st_empty;
            end
         end
         default: w_state_nxt = c_st_empty;
      endcase
   end

   // ------------------------------------------------------ handshake outputs
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (r_state)
         c_st_empty: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            out_last  = 1'b0;
         end
         c_st_shift: begin
            out_valid = 1'b1;
            out_last  = (r_ptr == c_last_lane);
            // Only accept the next word as the final lane leaves, so the
            // held word is never overwritten early and no bubble appears.
            in_ready  = out_last & out_ready;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            out_last  = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------- word / pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum   <= '0;
         r_carry <= '0;
         r_ptr   <= '0;
      end else if (w_in_fire) begin
         r_sum   <= in_sum;
         r_carry <= in_carry;
         r_ptr   <= c_first_lane;
      end else if (w_out_fire) begin
         r_ptr   <= w_ptr_step;
      end
   end

   // ------------------------------------------------------------ lane select
   always_comb begin
      w_lane_sum = r_sum[11:0];
      case (r_ptr)
         2'd0:    w_lane_sum = r_sum[11:0];
         2'd1:    w_lane_sum = r_sum[23:12];
         2'd2:    w_lane_sum = r_sum[35:24];
         default: w_lane_sum = r_sum[47:36];
      endcase
   end

   assign w_lane_carry = r_carry[r_ptr];
   assign out_lane     = r_ptr;

`ifdef QUAD_SUM_UNPACK_SATURATE_EN
   // Clamp an overflowing lane to the largest 12-bit value.
   assign out_sum = w_lane_carry ? 13'h0FFF : {1'b0, w_lane_sum};
`else
   assign out_sum = {w_lane_carry, w_lane_sum};
`endif

   // -------------------------------------------------------- overflow count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_cnt <= '0;
      end else if (ovf_clr) begin
         r_ovf_cnt <= '0;
      end else if (w_out_fire && w_lane_carry && (r_ovf_cnt != c_ovf_max)) begin
         r_ovf_cnt <= r_ovf_cnt + c_ovf_one;
      end
   end

   assign ovf_cnt = r_ovf_cnt;

endmodule
`default_nettype wire

// File: doc/quad_sum_unpack.md
QUAD_SUM_UNPACK -- requirements
Module: quad_sum_unpack

Interface
REQ-001 Parameter LANE_DESCEND, default 0: lane emission order; 0 = lanes 0,1,2,3; 1 = lanes 3,2,1,0.
REQ-002 Parameter OVF_CNT_W, default 16: width of the overflow counter.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 IN_SUM  input  48  packed FOUR12 sum word; lane n = bits [12n+11:12n].
REQ-006 IN_CARRY  input  4  per-lane carry-out; bit n = lane n bit 12.
REQ-007 IN_VALID  input  1  IN_SUM/IN_CARRY valid this cycle.
REQ-008 IN_READY  output  1  unpacker accepts the word this cycle.
REQ-009 OUT_SUM  output  13  unpacked lane sum {carry, 12-bit sum}.
REQ-010 OUT_LANE  output  2  lane index of OUT_SUM.
REQ-011 OUT_LAST  output  1  high on the final lane of a word.
REQ-012 OUT_VALID  output  1  OUT_* valid.
REQ-013 OUT_READY  input  1  downstream accepts OUT_* this cycle.
REQ-014 OVF_CLR  input  1  synchronous clear of OVF_CNT.
REQ-015 OVF_CNT  output  OVF_CNT_W  count of accepted lanes with carry set.

Function
REQ-016 Input transfer occurs when IN_VALID and IN_READY are both high in the same cycle; output transfer occurs when OUT_VALID and OUT_READY are both high in the same cycle.
REQ-017 FSM: EMPTY (no word held) and SHIFT (word held, lane pointer active).
REQ-018 EMPTY: IN_READY=1, OUT_VALID=0; an input transfer latches the word and carries, loads the pointer with the first lane, and moves to SHIFT.
REQ-019 SHIFT: OUT_VALID=1; OUT_SUM/OUT_LANE reflect the pointer lane; the pointer advances one lane per output transfer and holds while OUT_READY=0.
REQ-020 IN_READY in SHIFT = OUT_LAST AND OUT_READY (back-to-back words, no bubble).
REQ-021 Last-lane output transfer with a simultaneous input transfer: latch the new word, reload the pointer, stay in SHIFT.
REQ-022 Last-lane output transfer without an input transfer: go to EMPTY.
REQ-023 Latency: first lane is valid one cycle after the input transfer; sustained throughput is one lane per cycle (4 cycles per word).
REQ-024 OUT_* remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-025 OVF_CNT increments by one on each output transfer whose lane carry is 1, and saturates at all-ones without wrapping.
REQ-026 OVF_CLR has priority over a simultaneous increment; the counter becomes 0 that cycle.
REQ-027 IN_SUM/IN_CARRY are ignored when no input transfer occurs.

Reset
REQ-028 RST_N low asynchronously forces: state EMPTY, OUT_VALID=0, IN_READY=1 (combinational from state), OUT_SUM=0, OUT_LANE=0, OUT_LAST=0, OVF_CNT=0.
REQ-029 Reset mid-word discards the remaining lanes; no partial word is emitted after release.
REQ-030 The first transfer is accepted on the first rising edge after RST_N deasserts.

Configuration
REQ-031 Macro QUAD_SUM_UNPACK_SATURATE_EN defined: a lane with carry=1 is output as 13'h0FFF (clamped to 12 bits); OVF_CNT still counts that lane.
REQ-032 Macro QUAD_SUM_UNPACK_SATURATE_EN undefined: OUT_SUM = {carry, sum} unmodified.

Verification
REQ-033 Reset, then one word IN_SUM=48'h003_002_001_000, IN_CARRY=0, OUT_READY=1 -> OUT_SUM 0,1,2,3 on consecutive cycles; OUT_LAST only with 3; then back to EMPTY.
REQ-034 Two words presented back-to-back with OUT_READY=1 -> 8 contiguous output transfers, IN_READY high only on lane-3 cycles, no bubble.
REQ-035 Word lane1=12'hFFF, IN_CARRY=4'b0010 -> lane 1 emits 13'h1FFF (macro off) or 13'h0FFF (macro on); OVF_CNT=1 in both builds.
REQ-036 OUT_READY toggling randomly during a word -> OUT_* stable during stalls, lanes complete in order, no loss or duplication.
REQ-037 LANE_DESCEND=1 with word 48'h003_002_001_000 -> lanes emitted 3,2,1,0 with values 3,2,1,0; OUT_LAST with lane 0.
REQ-038 OVF_CNT preloaded near saturation via 4-bit OVF_CNT_W at 15 plus further carry lanes -> stays 15; OVF_CLR coincident with a carry lane -> 0.
